// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: IO-mapped SPI mode-0 master (MSB first) for the configuration flash.
// Rev 1.0 - initial release.
`default_nettype none

module spi_flash_ctrl #(
   parameter logic [15:0] BASE_ADDR = 16'd320,
   parameter logic [7:0]  DIV_RESET = 8'd0
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_wr,
   input  logic        io_rd,
   input  logic [15:0] mem_addr,
   input  logic [15:0] dout,
   output logic [15:0] rdata,
   output logic        spi_sck,
   output logic        spi_si,
   input  logic        spi_so,
   output logic        spi_ssb,
   output logic        done
);

   localparam logic [15:0] ADDR_DATA   = BASE_ADDR;
   localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + 16'd1;
   localparam logic [15:0] ADDR_STATUS = BASE_ADDR + 16'd2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_q,    rx_d;
   logic [7:0] div_q,   div_d;
   logic [7:0] cnt_q,   cnt_d;
   logic [2:0] bit_q,   bit_d;
   logic       sck_q,   sck_d;
   logic       si_q,    si_d;
   logic       cs_q,    cs_d;
   logic       done_q,  done_d;
   logic       ovr_q,   ovr_d;
   logic       rxv_q,   rxv_d;

   logic w_wr_data;
   logic w_wr_ctrl;
   logic w_rd_status;
   logic w_busy;
   logic w_half_end;

   assign w_wr_data   = io_wr & (mem_addr == ADDR_DATA);
   assign w_wr_ctrl   = io_wr & (mem_addr == ADDR_CTRL);
   assign w_rd_status = io_rd & (mem_addr == ADDR_STATUS);
   assign w_busy      = (state_q != IDLE);
   assign w_half_end  = (cnt_q == div_q);

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q <= IDLE;
         shift_q <= 8'd0;
         rx_q    <= 8'd0;
         div_q   <= DIV_RESET;
         cnt_q   <= 8'd0;
         bit_q   <= 3'd0;
         sck_q   <= 1'b0;
         si_q    <= 1'b0;
         cs_q    <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         rxv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sck_q   <= sck_d;
         si_q    <= si_d;
         cs_q    <= cs_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         rxv_q   <= rxv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sck_d   = sck_q;
      si_d    = si_q;
      cs_d    = cs_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      rxv_d   = rxv_q;

      // Status clears are applied first so that a same-cycle set overrides them.
      if (w_rd_status) begin
         ovr_d = 1'b0;
         rxv_d = 1'b0;
      end
      if (w_wr_data && w_busy) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (w_wr_data) begin
               shift_d = dout[7:0];
               si_d    = dout[7];
               cnt_d   = 8'd0;
               bit_d   = 3'd0;
               state_d = SHIFT_LO;
            end
            if (w_wr_ctrl) begin
               div_d = dout[15:8];
               cs_d  = dout[0];
            end
         end

         SHIFT_LO: begin
            if (w_half_end) begin
               cnt_d   = 8'd0;
               sck_d   = 1'b1;
               shift_d = {shift_q[6:0], spi_so};
               state_d = SHIFT_HI;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         SHIFT_HI: begin
            if (w_half_end) begin
               cnt_d = 8'd0;
               sck_d = 1'b0;
               if (bit_q == 3'd7) begin
                  rx_d    = shift_q;
                  rxv_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  si_d    = shift_q[7];
                  state_d = SHIFT_LO;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            sck_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rdata = 16'd0;
      if (mem_addr == ADDR_DATA) begin
         rdata = {8'd0, rx_q};
      end else if (mem_addr == ADDR_CTRL) begin
         rdata = {div_q, 7'd0, cs_q};
      end else if (mem_addr == ADDR_STATUS) begin
         rdata = {13'd0, ovr_q, rxv_q, w_busy};
      end
   end

   assign spi_sck = sck_q;
   assign spi_si  = si_q;
   assign spi_ssb = ~cs_q;
   assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed-vector bench for spi_flash_ctrl with a mode-0 flash responder.
// Rev 1.0 - initial release.
`default_nettype none

module tb_spi_flash_ctrl;

   localparam logic [15:0] A_DATA = 16'd320;
   localparam logic [15:0] A_CTRL = 16'd321;
   localparam logic [15:0] A_STAT = 16'd322;

   logic        clk = 1'b0;
   logic        resetq;
   logic        io_wr;
   logic        io_rd;
   logic [15:0] mem_addr;
   logic [15:0] dout;
   logic [15:0] rdata;
   logic        spi_sck;
   logic        spi_si;
   logic        spi_so;
   logic        spi_ssb;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_flash_ctrl #(
      .BASE_ADDR (16'd320),
      .DIV_RESET (8'd0)
   ) u_dut (
      .clk      (clk),
      .resetq   (resetq),
      .io_wr    (io_wr),
      .io_rd    (io_rd),
      .mem_addr (mem_addr),
      .dout     (dout),
      .rdata    (rdata),
      .spi_sck  (spi_sck),
      .spi_si   (spi_si),
      .spi_so   (spi_so),
      .spi_ssb  (spi_ssb),
      .done     (done)
   );

   // Flash responder: presents bit (7 - edges seen) of flash_tx, records SI on each rising SCK.
   int         nrise    = 0;
   int         base     = 0;
   logic [7:0] flash_tx = 8'd0;
   logic [7:0] mosi_sr  = 8'd0;

   always @(posedge spi_sck) begin
      nrise   <= nrise + 1;
      mosi_sr <= {mosi_sr[6:0], spi_si};
   end

   always_comb begin
      int k;
      k = 7 - (nrise - base);
      spi_so = (k >= 0 && k <= 7) ? flash_tx[k[2:0]] : 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
      mem_addr = addr;
      dout     = data;
      io_wr    = 1'b1;
      @(posedge clk);
      #1;
      io_wr    = 1'b0;
   endtask

   task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
      mem_addr = addr;
      io_rd    = 1'b1;
      #1;
      data     = rdata;
      @(posedge clk);
      #1;
      io_rd    = 1'b0;
   endtask

   task automatic peek(input logic [15:0] addr, output logic [15:0] data);
      mem_addr = addr;
      #1;
      data     = rdata;
   endtask

   task automatic start_xfer(input logic [7:0] tx);
      base     = nrise;
      flash_tx = tx;
   endtask

   task automatic wait_done(input int budget, output int cyc, output int hi);
      int got;
      cyc = 0;
      hi  = 0;
      got = 0;
      while (cyc < budget && got == 0) begin
         @(posedge clk);
         #1;
         cyc++;
         if (spi_sck) hi++;
         if (done) got = 1;
      end
      check("done_seen", got, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] d;
      int          cyc;
      int          hi;

      resetq   = 1'b0;
      io_wr    = 1'b0;
      io_rd    = 1'b0;
      mem_addr = A_STAT;
      dout     = 16'd0;

      // Reset state
      #12;
      check("rst_ssb", spi_ssb, 1'b1);
      check("rst_sck", spi_sck, 1'b0);
      check("rst_si", spi_si, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_status", rdata, 16'h0000);
      @(posedge clk);
      #1;
      resetq = 1'b1;
      @(posedge clk);
      #1;
      peek(A_CTRL, d);
      check("rst_ctrl", d, 16'h0000);

      // Basic transfer, div=0, cs=1
      io_write(A_CTRL, 16'h0001);
      check("basic_ssb", spi_ssb, 1'b0);
      start_xfer(8'h3C);
      io_write(A_DATA, 16'h00A5);
      peek(A_STAT, d);
      check("basic_busy", d, 16'h0001);
      wait_done(100, cyc, hi);
      check("basic_latency", cyc, 16);
      check("basic_sck_hi", hi, 8);
      check("basic_pulses", nrise - base, 8);
      check("basic_mosi", mosi_sr, 8'hA5);
      peek(A_STAT, d);
      check("basic_status_at_done", d, 16'h0002);
      io_read(A_DATA, d);
      check("basic_rx", d, 16'h003C);
      io_read(A_STAT, d);
      check("basic_status1", d, 16'h0002);
      io_read(A_STAT, d);
      check("basic_status2", d, 16'h0000);
      check("basic_si_hold", spi_si, 1'b1);

      // DATA write in the same cycle as done
      start_xfer(8'h96);
      io_write(A_DATA, 16'h0069);
      repeat (15) @(posedge clk);
      #1;
      io_write(A_DATA, 16'h00FF);
      check("coll_done", done, 1'b1);
      peek(A_STAT, d);
      check("coll_status", d, 16'h0006);
      check("coll_mosi", mosi_sr, 8'h69);
      io_read(A_DATA, d);
      check("coll_rx", d, 16'h0096);
      io_read(A_STAT, d);
      check("coll_status1", d, 16'h0006);
      io_read(A_STAT, d);
      check("coll_status2", d, 16'h0000);

      // Divider = 3
      io_write(A_CTRL, 16'h0301);
      peek(A_CTRL, d);
      check("div_ctrl", d, 16'h0301);
      start_xfer(8'hC3);
      io_write(A_DATA, 16'h005A);
      wait_done(300, cyc, hi);
      check("div_latency", cyc, 64);
      check("div_sck_hi", hi, 32);
      check("div_mosi", mosi_sr, 8'h5A);
      io_read(A_DATA, d);
      check("div_rx", d, 16'h00C3);
      io_read(A_STAT, d);
      check("div_status", d, 16'h0002);

      // Overrun
      start_xfer(8'h7E);
      io_write(A_DATA, 16'h0081);
      repeat (4) @(posedge clk);
      #1;
      io_write(A_DATA, 16'h00FF);
      wait_done(300, cyc, hi);
      check("ovr_mosi", mosi_sr, 8'h81);
      io_read(A_DATA, d);
      check("ovr_rx", d, 16'h007E);
      io_read(A_STAT, d);
      check("ovr_status1", d, 16'h0006);
      io_read(A_STAT, d);
      check("ovr_status2", d, 16'h0000);

      // CTRL write while busy
      start_xfer(8'h11);
      io_write(A_DATA, 16'h0033);
      repeat (3) @(posedge clk);
      #1;
      io_write(A_CTRL, 16'h0000);
      check("cbusy_ssb", spi_ssb, 1'b0);
      peek(A_CTRL, d);
      check("cbusy_ctrl", d, 16'h0301);
      wait_done(300, cyc, hi);
      check("cbusy_latency", cyc, 60);
      peek(A_STAT, d);
      check("cbusy_status", d, 16'h0002);
      check("cbusy_mosi", mosi_sr, 8'h33);
      io_read(A_DATA, d);
      check("cbusy_rx", d, 16'h0011);
      io_write(A_CTRL, 16'h0000);
      check("cbusy_ssb_off", spi_ssb, 1'b1);
      peek(A_CTRL, d);
      check("cbusy_ctrl_off", d, 16'h0000);

      // Reset in the middle of a transfer
      io_write(A_CTRL, 16'h0001);
      start_xfer(8'hFF);
      io_write(A_DATA, 16'h00F0);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (nrise - base >= 4) break;
      end
      check("mid_edges", nrise - base, 4);
      check("mid_sck_hi", spi_sck, 1'b1);
      resetq = 1'b0;
      #1;
      check("mid_sck", spi_sck, 1'b0);
      check("mid_ssb", spi_ssb, 1'b1);
      peek(A_STAT, d);
      check("mid_status", d, 16'h0000);
      @(posedge clk);
      #1;
      resetq = 1'b1;
      io_read(A_DATA, d);
      check("mid_rx", d, 16'h0000);
      peek(A_CTRL, d);
      check("mid_ctrl", d, 16'h0000);
      repeat (4) @(posedge clk);
      #1;
      check("mid_sck_idle", spi_sck, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
